// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state constants and op classification helpers for the
// iterative multiply/divide unit and the ALU control decoder.
package muldiv_pkg;

    typedef enum logic [4:0] {
        OP_MUL    = 5'b01011,
        OP_MULH   = 5'b01100,
        OP_MULHSU = 5'b01101,
        OP_MULHU  = 5'b01110,
        OP_DIV    = 5'b01111,
        OP_DIVU   = 5'b10000,
        OP_REM    = 5'b10001,
        OP_REMU   = 5'b10010
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    function automatic logic is_valid_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_mul(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_MULHU);
    endfunction

    function automatic logic is_high(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_rem(input logic [4:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_abs_neg.sv
// Conditional two's-complement: passes the value through or negates it.
// Negating the most negative value wraps to itself, which is the right magnitude.
module muldiv_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide engine: shift-add multiply and restoring
// divide at one result bit per cycle, valid/ready on both sides, flush abort.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic              div_zero_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t              state_reg, state_next;
    logic [CTRL_W-1:0]   op_reg, op_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [2*XLEN-1:0]   acc_reg, acc_next;
    logic [XLEN:0]       rem_reg, rem_next;
    logic [XLEN-1:0]     mcand_reg, mcand_next;
    logic                neg_reg, neg_next;
    logic [XLEN-1:0]     result_reg, result_next;
    logic                dz_reg, dz_next;

    logic                sign_a, sign_b, b_zero, div_ovf;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_step;
    logic [XLEN+1:0]     div_shift, div_diff;
    logic [2*XLEN-1:0]   fix_in, fix_out;
    logic [XLEN-1:0]     fix_res;

    // Operand conditioning on the incoming values (used only on the accept cycle)
    assign sign_a  = is_signed_a(op_i) & a_i[XLEN-1];
    assign sign_b  = is_signed_b(op_i) & b_i[XLEN-1];
    assign b_zero  = (b_i == '0);
    assign div_ovf = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                     (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);

    muldiv_abs_neg #(.W(XLEN)) u_abs_a (.val_i(a_i), .neg_i(sign_a), .val_o(abs_a));
    muldiv_abs_neg #(.W(XLEN)) u_abs_b (.val_i(b_i), .neg_i(sign_b), .val_o(abs_b));

    // Multiply step: the carry out of the upper-half add shifts back into the MSB
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, mcand_reg};
    assign mul_step = acc_reg[0] ? {mul_sum, acc_reg[XLEN-1:1]}
                                 : {1'b0, acc_reg[2*XLEN-1:1]};

    // Divide step: dividend/quotient lives in the low half of acc_reg
    assign div_shift = {rem_reg, acc_reg[XLEN-1]};
    assign div_diff  = div_shift - {2'b00, mcand_reg};

    assign fix_in = is_mul(op_reg) ? acc_reg
                  : {{XLEN{1'b0}}, (is_rem(op_reg) ? rem_reg[XLEN-1:0] : acc_reg[XLEN-1:0])};

    muldiv_abs_neg #(.W(2*XLEN)) u_fix (.val_i(fix_in), .neg_i(neg_reg), .val_o(fix_out));

    assign fix_res = is_high(op_reg) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        rem_next    = rem_reg;
        mcand_next  = mcand_reg;
        neg_next    = neg_reg;
        result_next = result_reg;
        dz_next     = dz_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid_i && !flush_i) begin
                    op_next     = op_i;
                    dz_next     = 1'b0;
                    result_next = '0;
                    neg_next    = is_rem(op_i) ? sign_a : (sign_a ^ sign_b);
                    if (!is_valid_op(op_i)) begin
                        state_next = ST_DONE;
                    end else if (!is_mul(op_i) && b_zero) begin
                        dz_next     = 1'b1;
                        result_next = is_rem(op_i) ? a_i : '1;
                        state_next  = ST_DONE;
                    end else if (div_ovf) begin
                        result_next = is_rem(op_i) ? '0 : a_i;
                        state_next  = ST_DONE;
                    end else begin
                        cnt_next   = CNT_W'(XLEN);
                        mcand_next = is_mul(op_i) ? abs_a : abs_b;
                        acc_next   = {{XLEN{1'b0}}, (is_mul(op_i) ? abs_b : abs_a)};
                        rem_next   = '0;
                        state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (is_mul(op_reg)) begin
                    acc_next = mul_step;
                end else begin
                    acc_next = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-2:0], ~div_diff[XLEN+1]};
                    rem_next = div_diff[XLEN+1] ? div_shift[XLEN:0] : div_diff[XLEN:0];
                end
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                result_next = fix_res;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (flush_i) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            rem_reg    <= '0;
            mcand_reg  <= '0;
            neg_reg    <= 1'b0;
            result_reg <= '0;
            dz_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            rem_reg    <= rem_next;
            mcand_reg  <= mcand_next;
            neg_reg    <= neg_next;
            result_reg <= result_next;
            dz_reg     <= dz_next;
        end
    end

    assign in_ready_o  = (state_reg == ST_IDLE) && !flush_i;
    assign out_valid_o = (state_reg == ST_DONE);
    assign result_o    = result_reg;
    assign div_zero_o  = dz_reg;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine executing the RV32M/RV64M operations selected by the 5-bit ALU control codes 01011..10010.
- Sits beside the single-cycle ALU in execute. The ALU control decoder drives op_i, and the pipeline stalls on in_ready_o/out_valid_o.
- Uses shift-add multiplication and restoring division: one result bit per cycle, with a valid/ready handshake on both sides and a flush input.

Parameters:
- XLEN, 32: operand/result width; legal values 32 and 64.
- CTRL_W, 5: width of the op code, matching ALU control.
- CNT_W, $clog2(XLEN)+1: iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort of any in-flight operation.
- in_valid_i  in  1  operands and op are valid.
- in_ready_o  out  1  unit can accept (state IDLE).
- op_i  in  CTRL_W  01011 MUL, 01100 MULH, 01101 MULHSU, 01110 MULHU, 01111 DIV, 10000 DIVU, 10001 REM, 10010 REMU.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- out_valid_o  out  1  result is valid.
- out_ready_i  in  1  consumer takes the result.
- result_o  out  XLEN  result.
- div_zero_o  out  1  qualifier, valid with out_valid_o: divisor was zero (DIV/DIVU/REM/REMU).

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state=IDLE, in_ready_o=1, out_valid_o=0, result_o=0, div_zero_o=0;
  - all internal registers to 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o, latch op_i, a_i, b_i (accept cycle = N).
  - Take absolute values for signed operands: MULH both, MULHSU a only, DIV/REM both.
  - Record the result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Load counter = XLEN and go to CALC, except for the special cases below.
- Special cases go directly IDLE->DONE, with out_valid_o=1 at N+1:
  - DIV/DIVU with b=0: result all ones, div_zero_o=1.
  - REM/REMU with b=0: result a_i, div_zero_o=1.
  - DIV with a=signed min and b=-1: result signed min. REM with the same operands: result 0.
  - Any op_i outside 01011..10010: result 0.
- CALC, one iteration per cycle, counter decrements, exit to FIX when counter reaches 1:
  - MUL: 2*XLEN-bit accumulator. If multiplier LSB is set, add multiplicand into the upper half; then shift right by 1.
  - DIV: shift remainder:dividend left by 1; trial-subtract the divisor; if non-negative, keep the result and set quotient LSB.
- FIX (1 cycle):
  - Apply two's-complement negation when the recorded sign is set.
  - Select the low half (MUL), high half (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU).
  - Register result_o; go to DONE.
- Normal latency: accept at cycle N gives out_valid_o=1 at N+XLEN+2.
- DONE:
  - out_valid_o=1.
  - result_o and div_zero_o are held stable until out_ready_i.
  - On out_valid_o&out_ready_i: go to IDLE and drop out_valid_o the next cycle.
  - No new accept in the same cycle as the result handoff; in_ready_o goes high the cycle after.
- flush_i:
  - In any state, next state is IDLE, out_valid_o=0, and the result is discarded.
  - flush_i has priority over accept and handoff in the same cycle.
  - In IDLE, flush_i forces in_ready_o=0 for that cycle.
- Inputs are ignored outside IDLE. Latched operands are immune to later changes on a_i, b_i, op_i.
- Width rules:
  - Remainder register is XLEN+1 bits for the trial subtract.
  - Negating signed min wraps to itself, which is the correct unsigned magnitude.

Decomposition:
- Package muldiv_pkg:
  - typedef enum for the op codes, shared with the ALU control decoder;
  - state enum;
  - helpers is_mul(op), is_signed_a(op), is_signed_b(op).
- One natural sub-module: muldiv_abs_neg, a conditional two's-complement unit. It is instantiated for operand conditioning and for FIX.

Test Plan (XLEN=32):
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; out_valid_o at N+34; in_ready_o=0 from N+1 until handoff.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD. REM a=-7, b=2 -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2.
- Special cases, each with out_valid_o at N+1:
  - DIV x/0 -> 0xFFFFFFFF, div_zero_o=1.
  - REMU a=0x1234/0 -> 0x1234, div_zero_o=1.
  - DIV 0x80000000/-1 -> 0x80000000, div_zero_o=0.
  - REM 0x80000000/-1 -> 0.
- Backpressure and flush:
  - Hold out_ready_i=0 for 5 cycles in DONE -> result_o stable and out_valid_o held.
  - flush_i at CALC cycle 10 -> IDLE next cycle, no out_valid_o; a following MUL 3*5 -> 15.
- Reset: rst_n low mid-CALC, asynchronous -> all outputs at reset values immediately, in_ready_o=1 once rst_n is released.
- Unknown op 00101 -> result 0 at N+1.
